// File: rtl/mem_pkg.sv
// Shared types and constants for the M-stage load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mem_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam logic [31:0] ERR_DATA           = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory system (slave).
interface mem_stage_lsu_if;

    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [3:0]  DBe;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DAck;

    modport master (
        output DReq, DWe, DAddr, DBe, DWData,
        input  DRData, DAck
    );

    modport slave (
        input  DReq, DWe, DAddr, DBe, DWData,
        output DRData, DAck
    );

endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane steering: store enables/replication and byte-load extraction.
module mem_lane_fmt (
    input  logic        st_byte_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic        ld_byte_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0] ld_lane;

    always_comb begin
        be_o    = st_byte_i ? (4'b0001 << st_off_i) : 4'hF;
        wdata_o = st_byte_i ? {4{st_data_i[7:0]}} : st_data_i;

        unique case (ld_off_i)
            2'd0:    ld_lane = rdata_i[7:0];
            2'd1:    ld_lane = rdata_i[15:8];
            2'd2:    ld_lane = rdata_i[23:16];
            default: ld_lane = rdata_i[31:24];
        endcase

        ld_data_o = ld_byte_i ? {24'b0, ld_lane} : rdata_i;
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one bus access per request, stalls the pipe while BUSY,
// aborts with ErrM after TIMEOUT_CYCLES unacknowledged cycles.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemReadM,
    input  logic                   MemWriteM,
    input  logic                   ByteM,
    input  logic [31:0]            ALUOutM,
    input  logic [31:0]            WriteDataM,
    mem_stage_lsu_if.master        bus,
    output logic [31:0]            ReadDataM,
    output logic                   StallM,
    output logic                   ErrM
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    mem_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        dreq_q, dreq_d;
    logic        dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d;
    logic [3:0]  dbe_q, dbe_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        byte_q, byte_d;
    logic [1:0]  off_q, off_d;
    logic        stall;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // Store path formats live M-stage operands at issue; load path uses the latched access.
    mem_lane_fmt u_lane_fmt (
        .st_byte_i (ByteM),
        .st_off_i  (ALUOutM[1:0]),
        .st_data_i (WriteDataM),
        .be_o      (st_be),
        .wdata_o   (st_wdata),
        .ld_byte_i (byte_q),
        .ld_off_i  (off_q),
        .rdata_i   (bus.DRData),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dreq_d   = dreq_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dbe_d    = dbe_q;
        dwdata_d = dwdata_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        byte_d   = byte_q;
        off_d    = off_q;
        stall    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (MemReadM || MemWriteM) begin
                    stall    = 1'b1;
                    state_d  = StBusy;
                    cnt_d    = '0;
                    dreq_d   = 1'b1;
                    dwe_d    = MemWriteM;
                    daddr_d  = {ALUOutM[31:2], 2'b00};
                    dbe_d    = st_be;
                    dwdata_d = st_wdata;
                    byte_d   = ByteM;
                    off_d    = ALUOutM[1:0];
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // An ack in the timeout cycle still completes the access normally.
                if (bus.DAck) begin
                    state_d = StDone;
                    dreq_d  = 1'b0;
                    dwe_d   = 1'b0;
                    if (!dwe_q) begin
                        rdata_d = ld_data;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    dreq_d  = 1'b0;
                    dwe_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!dwe_q) begin
                        rdata_d = ERR_DATA;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dbe_q    <= '0;
            dwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            byte_q   <= 1'b0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dbe_q    <= dbe_d;
            dwdata_q <= dwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            byte_q   <= byte_d;
            off_q    <= off_d;
        end
    end

    assign bus.DReq   = dreq_q;
    assign bus.DWe    = dwe_q;
    assign bus.DAddr  = daddr_q;
    assign bus.DBe    = dbe_q;
    assign bus.DWData = dwdata_q;
    assign ReadDataM  = rdata_q;
    assign ErrM       = err_q;
    // Pending requests must not stall a pipeline that is held in reset.
    assign StallM     = stall & reset;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES = 4).
module tb_mem_stage_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, ByteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, ErrM;

    int n_checks = 0;
    int n_fail   = 0;

    int          stall_n, dreq_n, err_n, hold_bad;
    logic        done_seen;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .bus        (bus_if),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .ErrM       (ErrM)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic bt,
                           input logic [31:0] a, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        ByteM      = bt;
        ALUOutM    = a;
        WriteDataM = wd;
    endtask

    // Called 1 time unit after a posedge with the request already driven in IDLE.
    // Returns in the DONE cycle; ack_at = 0 means never acknowledge.
    task automatic run_access(input int ack_at, input logic [31:0] rd);
        int busy_idx = 0;
        stall_n   = 0;
        dreq_n    = 0;
        err_n     = 0;
        hold_bad  = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            #1;
            if (c > 0 && !StallM) begin
                done_seen   = 1'b1;
                bus_if.DAck = 1'b0;
                if (ErrM) err_n++;
            end else begin
                if (StallM) stall_n++;
                if (ErrM) err_n++;
                if (bus_if.DReq) begin
                    dreq_n++;
                    busy_idx++;
                    if (busy_idx == 1) begin
                        cap_addr  = bus_if.DAddr;
                        cap_be    = bus_if.DBe;
                        cap_wdata = bus_if.DWData;
                        cap_we    = bus_if.DWe;
                    end else if (bus_if.DAddr !== cap_addr || bus_if.DBe !== cap_be ||
                                 bus_if.DWData !== cap_wdata || bus_if.DWe !== cap_we) begin
                        hold_bad++;
                    end
                end
                bus_if.DAck   = bus_if.DReq && (ack_at != 0) && (busy_idx == ack_at);
                bus_if.DRData = rd;
                tick();
            end
        end
        if (!done_seen) begin
            $display("FAIL access_watchdog: DONE not reached, got stall_n=%0d required DONE", stall_n);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        bus_if.DAck = 1'b0;
        bus_if.DRData = 32'h0;
        #12;
        if (StallM !== 1'b0) begin $display("FAIL rst_stall: got %b required 0", StallM); n_fail++; end
        n_checks++;
        if (bus_if.DReq !== 1'b0 || bus_if.DWe !== 1'b0) begin
            $display("FAIL rst_dreq: got %b/%b required 0/0", bus_if.DReq, bus_if.DWe); n_fail++; end
        n_checks++;
        if (bus_if.DAddr !== 32'h0 || bus_if.DBe !== 4'h0 || bus_if.DWData !== 32'h0) begin
            $display("FAIL rst_bus: got %h/%h/%h required 0", bus_if.DAddr, bus_if.DBe, bus_if.DWData);
            n_fail++; end
        n_checks++;
        if (ReadDataM !== 32'h0 || ErrM !== 1'b0) begin
            $display("FAIL rst_rdata: got %h/%b required 0/0", ReadDataM, ErrM); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ldr_word();
        set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        run_access(3, 32'h1234_5678);
        if (stall_n !== 4) begin $display("FAIL ldr_stall: got %0d required 4", stall_n); n_fail++; end
        n_checks++;
        if (dreq_n !== 3) begin $display("FAIL ldr_dreq: got %0d required 3", dreq_n); n_fail++; end
        n_checks++;
        if (cap_addr !== 32'h100 || cap_be !== 4'hF || cap_we !== 1'b0) begin
            $display("FAIL ldr_bus: got %h/%h/%b required 00000100/f/0", cap_addr, cap_be, cap_we);
            n_fail++; end
        n_checks++;
        if (hold_bad !== 0) begin $display("FAIL ldr_hold: got %0d required 0", hold_bad); n_fail++; end
        n_checks++;
        if (ReadDataM !== 32'h1234_5678 || bus_if.DReq !== 1'b0 || err_n !== 0) begin
            $display("FAIL ldr_done: got %h/%b/%0d required 12345678/0/0",
                     ReadDataM, bus_if.DReq, err_n); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        if (StallM !== 1'b0 || bus_if.DReq !== 1'b0) begin
            $display("FAIL ldr_idle: got %b/%b required 0/0", StallM, bus_if.DReq); n_fail++; end
        n_checks++;

        // Low address bits are ignored for word accesses.
        set_req(1'b1, 1'b0, 1'b0, 32'h107, 32'h0);
        run_access(1, 32'h8765_4321);
        if (cap_addr !== 32'h104 || cap_be !== 4'hF || ReadDataM !== 32'h8765_4321) begin
            $display("FAIL ldr_unaligned: got %h/%h/%h required 00000104/f/87654321",
                     cap_addr, cap_be, ReadDataM); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_strb();
        set_req(1'b0, 1'b1, 1'b1, 32'h203, 32'h0000_00AB);
        run_access(1, 32'hFFFF_FFFF);
        if (cap_be !== 4'b1000 || cap_wdata !== 32'hABAB_ABAB || cap_we !== 1'b1) begin
            $display("FAIL strb_bus: got %h/%h/%b required 8/ababab ab/1", cap_be, cap_wdata, cap_we);
            n_fail++; end
        n_checks++;
        if (cap_addr !== 32'h200 || stall_n !== 2) begin
            $display("FAIL strb_addr: got %h/%0d required 00000200/2", cap_addr, stall_n); n_fail++; end
        n_checks++;
        if (ReadDataM !== 32'h8765_4321) begin
            $display("FAIL strb_rdata: got %h required 87654321", ReadDataM); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_ldrb();
        set_req(1'b1, 1'b0, 1'b1, 32'h202, 32'h0);
        run_access(1, 32'h1122_3344);
        if (ReadDataM !== 32'h0000_0022) begin
            $display("FAIL ldrb_rdata: got %h required 00000022", ReadDataM); n_fail++; end
        n_checks++;
        if (stall_n !== 2 || cap_addr !== 32'h200) begin
            $display("FAIL ldrb_stall: got %0d/%h required 2/00000200", stall_n, cap_addr); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_timeout();
        set_req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
        run_access(0, 32'h0);
        if (dreq_n !== 4 || stall_n !== 5) begin
            $display("FAIL to_cycles: got dreq %0d stall %0d required 4/5", dreq_n, stall_n); n_fail++; end
        n_checks++;
        if (err_n !== 1 || ErrM !== 1'b1) begin
            $display("FAIL to_err: got %0d/%b required 1/1", err_n, ErrM); n_fail++; end
        n_checks++;
        if (ReadDataM !== ERR_DATA) begin
            $display("FAIL to_rdata: got %h required deadbeef", ReadDataM); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        if (ErrM !== 1'b0 || StallM !== 1'b0 || bus_if.DReq !== 1'b0) begin
            $display("FAIL to_idle: got %b/%b/%b required 0/0/0", ErrM, StallM, bus_if.DReq); n_fail++; end
        n_checks++;

        // Ack in the last allowed cycle beats the timeout.
        set_req(1'b1, 1'b0, 1'b0, 32'h304, 32'h0);
        run_access(4, 32'hCAFE_F00D);
        if (err_n !== 0 || ReadDataM !== 32'hCAFE_F00D || dreq_n !== 4) begin
            $display("FAIL to_ack_wins: got %0d/%h/%0d required 0/cafef00d/4", err_n, ReadDataM, dreq_n);
            n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_busy();
        set_req(1'b1, 1'b0, 1'b0, 32'h400, 32'h0);
        tick();
        tick();
        if (bus_if.DReq !== 1'b1) begin $display("FAIL rmb_busy: got %b required 1", bus_if.DReq); n_fail++; end
        n_checks++;
        reset = 1'b0;
        #1;
        if (bus_if.DReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0 ||
            bus_if.DAddr !== 32'h0 || ErrM !== 1'b0) begin
            $display("FAIL rmb_clear: got %b/%b/%h/%h/%b required 0/0/0/0/0",
                     bus_if.DReq, StallM, ReadDataM, bus_if.DAddr, ErrM); n_fail++; end
        n_checks++;
        bus_if.DAck   = 1'b1;
        bus_if.DRData = 32'h5555_5555;
        tick();
        bus_if.DAck = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        bus_if.DAck = 1'b1;
        tick();
        bus_if.DAck = 1'b0;
        if (ReadDataM !== 32'h0 || bus_if.DReq !== 1'b0) begin
            $display("FAIL rmb_late_ack: got %h/%b required 0/0", ReadDataM, bus_if.DReq); n_fail++; end
        n_checks++;
        set_req(1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
        run_access(2, 32'h0BAD_CAFE);
        if (ReadDataM !== 32'h0BAD_CAFE || stall_n !== 3 || cap_addr !== 32'h500) begin
            $display("FAIL rmb_next: got %h/%0d/%h required 0badcafe/3/00000500",
                     ReadDataM, stall_n, cap_addr); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        run_access(1, 32'hA5A5_0001);
        if (cap_addr !== 32'h10 || cap_we !== 1'b0 || ReadDataM !== 32'hA5A5_0001) begin
            $display("FAIL b2b_ld: got %h/%b/%h required 00000010/0/a5a50001", cap_addr, cap_we, ReadDataM);
            n_fail++; end
        n_checks++;
        // Next instruction reaches M during DONE; it must not be issued yet.
        set_req(1'b0, 1'b1, 1'b0, 32'h14, 32'h0000_0077);
        #1;
        if (StallM !== 1'b0 || bus_if.DReq !== 1'b0) begin
            $display("FAIL b2b_done: got %b/%b required 0/0", StallM, bus_if.DReq); n_fail++; end
        n_checks++;
        tick();
        run_access(1, 32'h0);
        if (cap_addr !== 32'h14 || cap_we !== 1'b1 || cap_wdata !== 32'h77 || dreq_n !== 1) begin
            $display("FAIL b2b_st: got %h/%b/%h/%0d required 00000014/1/00000077/1",
                     cap_addr, cap_we, cap_wdata, dreq_n); n_fail++; end
        n_checks++;
        if (ReadDataM !== 32'hA5A5_0001) begin
            $display("FAIL b2b_rdata: got %h required a5a50001", ReadDataM); n_fail++; end
        n_checks++;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        if (bus_if.DReq !== 1'b0 || StallM !== 1'b0) begin
            $display("FAIL b2b_idle: got %b/%b required 0/0", bus_if.DReq, StallM); n_fail++; end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_ldr_word();
        test_strb();
        test_ldrb();
        test_timeout();
        test_reset_mid_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max BUSY cycles waiting for DAck before abort.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 reset  in  1  asynchronous, active-low (0 = reset).
REQ-004 MemReadM  in  1  M-stage load request (LDR/LDRB).
REQ-005 MemWriteM  in  1  M-stage store request (STR/STRB).
REQ-006 ByteM  in  1  1 = byte access, 0 = word access.
REQ-007 ALUOutM  in  32  effective address.
REQ-008 WriteDataM  in  32  store data.
REQ-009 DReq  out  1  data-memory request.
REQ-010 DWe  out  1  1 = write, 0 = read; valid while DReq.
REQ-011 DAddr  out  32  bus address, word-aligned.
REQ-012 DBe  out  4  byte-lane enables.
REQ-013 DWData  out  32  write data.
REQ-014 DRData  in  32  read data, valid with DAck.
REQ-015 DAck  in  1  memory completion, single-cycle pulse.
REQ-016 ReadDataM  out  32  formatted load data, feeds M->W register.
REQ-017 StallM  out  1  freeze F/D/E/M stages.
REQ-018 ErrM  out  1  one-cycle pulse on access timeout.

Function
REQ-019 FSM states IDLE, BUSY, DONE; state, counter, bus outputs and ReadDataM registered.
REQ-020 IDLE: MemReadM|MemWriteM -> StallM=1 combinationally same cycle, latch address/data/byte/dir, next BUSY; else stay, StallM=0.
REQ-021 MemReadM and MemWriteM both 1 -> treated as store.
REQ-022 BUSY: DReq=1, DWe/DAddr/DBe/DWData held stable; StallM=1; counter increments each cycle.
REQ-023 BUSY with DAck=1 -> loads capture formatted DRData into ReadDataM; next DONE; DReq deasserts next cycle.
REQ-024 BUSY, counter reaches TIMEOUT_CYCLES-1 with DAck=0 -> ReadDataM=32'hDEAD_BEEF if load, ErrM=1 in DONE, next DONE.
REQ-025 DAck in same cycle as timeout -> DAck wins, no error.
REQ-026 DONE: StallM=0, DReq=0 for exactly one cycle; next IDLE unconditionally (no re-issue of same instruction).
REQ-027 Minimum access: 3 cycles (IDLE, BUSY with immediate ack, DONE), StallM high for 2.
REQ-028 Word: DAddr={ALUOutM[31:2],2'b00}, DBe=4'hF, DWData=WriteDataM; ALUOutM[1:0] ignored.
REQ-029 Byte store: DBe=4'b0001<<ALUOutM[1:0], DWData=WriteDataM[7:0] replicated on all four lanes.
REQ-030 Byte load: ReadDataM={24'b0, DRData lane ALUOutM[1:0]}.
REQ-031 Stores and non-memory cycles leave ReadDataM unchanged.
REQ-032 DAck outside BUSY ignored.
REQ-033 Counter clears on entry to BUSY; never wraps.

Reset
REQ-034 reset=0 asynchronously forces IDLE, counter=0, DReq=DWe=0, DAddr=DBe=DWData=0, ReadDataM=0, ErrM=0.
REQ-035 StallM=0 while reset=0, even with requests pending.
REQ-036 Reset mid-BUSY abandons the access; any later DAck ignored.
REQ-037 First request evaluated on first rising edge after reset deasserts.

Structure
REQ-038 Package mem_pkg holds FSM state enum, TIMEOUT_CYCLES default, ERR_DATA=32'hDEAD_BEEF.
REQ-039 Combinational lane steering (DBe, DWData replication, byte-load extract) in sub-module mem_lane_fmt.

Verification
REQ-040 LDR addr 0x100, DAck after 3 BUSY cycles, DRData 0x1234_5678 -> DAddr 0x100, DBe 4'hF, StallM 4 cycles, ReadDataM 0x1234_5678 in DONE.
REQ-041 STRB addr 0x203, WriteDataM 0xAB -> DBe 4'b1000, DWData 0xABAB_ABAB, DWe=1, ReadDataM unchanged.
REQ-042 LDRB addr 0x202, DRData 0x11223344, immediate ack -> ReadDataM 0x0000_0022, StallM 2 cycles.
REQ-043 TIMEOUT_CYCLES=4, load never acked -> DReq high 4 cycles, ErrM one pulse, ReadDataM 0xDEAD_BEEF, FSM back to IDLE.
REQ-044 reset=0 asserted mid-BUSY, late DAck -> all outputs 0 immediately, no capture, next load completes normally.
REQ-045 Back-to-back LDR 0x10 then STR 0x14 -> two distinct bus transactions, no duplicate issue in DONE cycle.
